dynrama_release_ctrl: RTL and testbench

- Synthesizable page-pool release engine for the dynrama memory map. It is the free side of the allocator.
- It tracks allocation state of NUM_PAGES fixed-size pages starting at BASE_ADDR in a page bitmap.
- The allocator-side mark port sets page bits; free requests (addr, size) are validated and their pages cleared.
- Sits between the allocation requester and the pool, and reports per-request status and free page count.

---
 rtl/dynrama_release_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dynrama_release_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dynrama_release_ctrl.sv
// dynrama_release_ctrl: free side of the dynrama page allocator.
// Tracks page allocation in a bitmap. The mark port sets bits. Free requests
// (addr, size) are validated, then scanned for double free, then released one
// page per cycle. Each free produces exactly one response strobe.
module dynrama_release_ctrl #(
    parameter int                AWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                PAGE_SHIFT = 12,
    parameter int                NUM_PAGES  = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mark_valid,
    input  logic [$clog2(NUM_PAGES)-1:0]   mark_idx,
    output logic                           mark_err,
    input  logic                           free_valid,
    output logic                           free_ready,
    input  logic [AWIDTH-1:0]              free_addr,
    input  logic [AWIDTH:0]                free_size,
    output logic                           rsp_valid,
    output logic [1:0]                     rsp_status,
    output logic [$clog2(NUM_PAGES+1)-1:0] rsp_pages,
    output logic [$clog2(NUM_PAGES+1)-1:0] free_count,
    output logic                           busy
);
    localparam int IW = $clog2(NUM_PAGES);
    localparam int CW = $clog2(NUM_PAGES + 1);
    // Range arithmetic runs two bits wider than the address so nothing wraps.
    localparam int EW = AWIDTH + 2;
    localparam logic [EW-1:0] LIMIT = EW'(NUM_PAGES) << PAGE_SHIFT;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_SCAN    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_RANGE  = 2'd2;
    localparam logic [1:0] ST_DOUBLE = 2'd3;

    logic [2:0]           state;
    logic [NUM_PAGES-1:0] bitmap;
    logic [AWIDTH-1:0]    addr_q;
    logic [AWIDTH:0]      size_q;
    logic [IW-1:0]        start_q;
    logic [IW-1:0]        idx_q;
    logic [CW-1:0]        n_q;
    logic [1:0]           status_q;
    logic [CW-1:0]        pages_q;

    logic [EW-1:0] addr_x, size_x, base_x, off_x, end_x;
    logic          misaligned, out_of_range;
    logic [IW-1:0] cur_page;
    logic          last_step;
    logic          mark_in_range, mark_ok, release_clr;

    // Validation of the latched request, evaluated while in CHECK.
    assign addr_x       = EW'(addr_q);
    assign size_x       = EW'(size_q);
    assign base_x       = EW'(BASE_ADDR);
    assign off_x        = addr_x - base_x;
    assign end_x        = off_x + size_x;
    assign misaligned   = (|addr_q[PAGE_SHIFT-1:0]) || (|size_q[PAGE_SHIFT-1:0]) || (size_q == '0);
    assign out_of_range = (addr_x < base_x) || (end_x > LIMIT);

    // Page walk shared by SCAN and RELEASE; start+idx never leaves the pool.
    assign cur_page  = start_q + idx_q;
    assign last_step = (CW'(idx_q) + CW'(1)) == n_q;

    // A mark succeeds only on a clear, existing page; the release clear never
    // targets a clear page, so the two can never collide on the same bit.
    assign mark_in_range = {1'b0, mark_idx} < (IW + 1)'(NUM_PAGES);
    assign mark_ok       = mark_valid && mark_in_range && !bitmap[mark_idx];
    assign release_clr   = (state == S_RELEASE);

    assign free_ready = (state == S_IDLE);
    assign busy       = !free_ready;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_status = rsp_valid ? status_q : 2'd0;
    assign rsp_pages  = rsp_valid ? pages_q : '0;

    // Free-request FSM: accept, validate, scan for double free, release, respond.
    // NOTE: all state here uses non-blocking assignment so every branch sees
    // the pre-edge values of bitmap and counters, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            start_q  <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            status_q <= ST_OK;
            pages_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (free_valid) begin
                        addr_q <= free_addr;
                        size_q <= free_size;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    idx_q   <= '0;
                    start_q <= IW'(off_x >> PAGE_SHIFT);
                    n_q     <= CW'(size_x >> PAGE_SHIFT);
                    pages_q <= '0;
                    if (misaligned) begin
                        status_q <= ST_ALIGN;
                        state    <= S_RESP;
                    end else if (out_of_range) begin
                        status_q <= ST_RANGE;
                        state    <= S_RESP;
                    end else begin
                        status_q <= ST_OK;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!bitmap[cur_page]) begin
                        status_q <= ST_DOUBLE;
                        state    <= S_RESP;
                    end else if (last_step) begin
                        idx_q <= '0;
                        state <= S_RELEASE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_RELEASE: begin
                    if (last_step) begin
                        pages_q <= n_q;
                        state   <= S_RESP;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Page bitmap and free counter: mark sets, release clears, both may coincide.
    // NOTE: the bitmap is flop-based and must be reset, since free_count is
    // defined against it; it is never mapped onto a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap     <= '0;
            free_count <= CW'(NUM_PAGES);
            mark_err   <= 1'b0;
        end else begin
            mark_err <= mark_valid && !mark_ok;
            if (release_clr) bitmap[cur_page] <= 1'b0;
            if (mark_ok)     bitmap[mark_idx] <= 1'b1;
            case ({release_clr, mark_ok})
                2'b10:   free_count <= free_count + CW'(1);
                2'b01:   free_count <= free_count - CW'(1);
                default: free_count <= free_count;
            endcase
        end
    end
endmodule

// File: tb/tb_dynrama_release_ctrl.sv
// Self-checking bench for dynrama_release_ctrl: directed scenarios with
// hand-computed expectations plus a randomized run against a page-level model.
module tb_dynrama_release_ctrl;
    localparam int          NP    = 64;
    localparam int          IW    = 6;
    localparam int          CW    = 7;
    localparam longint      BASE  = 64'h1000_0000;
    localparam longint      PAGE  = 4096;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mark_valid = 1'b0;
    logic [IW-1:0]   mark_idx = '0;
    logic            mark_err;
    logic            free_valid = 1'b0;
    logic            free_ready;
    logic [31:0]     free_addr = '0;
    logic [32:0]     free_size = '0;
    logic            rsp_valid;
    logic [1:0]      rsp_status;
    logic [CW-1:0]   rsp_pages;
    logic [CW-1:0]   free_count;
    logic            busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dynrama_release_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mark_valid(mark_valid), .mark_idx(mark_idx), .mark_err(mark_err),
        .free_valid(free_valid), .free_ready(free_ready),
        .free_addr(free_addr), .free_size(free_size),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_pages(rsp_pages),
        .free_count(free_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The pool is a set of allocated pages. A free request is accepted, then
    // after one cycle of validation it inspects page start+j at relative step
    // j+2, releases page start+j at step n+2+j, and answers for one cycle.
    bit     mbm[NP];
    bit     m_busy, m_resp;
    int     m_rel, m_n, m_start, m_vstat;
    int     exp_status, exp_pages;
    bit     exp_mark_err;

    function automatic int model_free_pages();
        int c = 0;
        for (int i = 0; i < NP; i++) if (!mbm[i]) c++;
        return c;
    endfunction

    function automatic int validate(input longint a, input longint s);
        if ((a % PAGE) != 0 || (s % PAGE) != 0 || s == 0) return 1;
        if (a < BASE || (a - BASE) + s > NP * PAGE) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) mbm[i] = 1'b0;
        m_busy = 0; m_resp = 0; m_rel = 0; m_n = 0; m_start = 0; m_vstat = 0;
        exp_status = 0; exp_pages = 0; exp_mark_err = 0;
    endtask

    task automatic model_step();
        int mark_set;
        mark_set = -1;
        exp_mark_err = 0;
        if (mark_valid) begin
            if (int'(mark_idx) < NP && !mbm[mark_idx]) mark_set = int'(mark_idx);
            else exp_mark_err = 1;
        end
        if (!m_busy) begin
            if (free_valid) begin
                m_busy  = 1; m_resp = 0; m_rel = 0;
                m_vstat = validate(longint'(free_addr), longint'(free_size));
                m_n     = int'(free_size / PAGE);
                m_start = int'((longint'(free_addr) - BASE) / PAGE);
            end
        end else if (m_resp) begin
            m_busy = 0; m_resp = 0;
        end else begin
            m_rel++;
            if (m_rel == 1) begin
                if (m_vstat != 0) begin m_resp = 1; exp_status = m_vstat; exp_pages = 0; end
            end else if (m_rel <= m_n + 1) begin
                if (!mbm[m_start + m_rel - 2]) begin m_resp = 1; exp_status = 3; exp_pages = 0; end
            end else begin
                mbm[m_start + m_rel - m_n - 2] = 1'b0;
                if (m_rel == 2 * m_n + 1) begin m_resp = 1; exp_status = 0; exp_pages = m_n; end
            end
        end
        if (mark_set >= 0) mbm[mark_set] = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("free_ready", free_ready, !m_busy);
                check("busy", busy, m_busy);
                check("rsp_valid", rsp_valid, m_resp);
                check("rsp_status", rsp_status, m_resp ? exp_status : 0);
                check("rsp_pages", rsp_pages, m_resp ? exp_pages : 0);
                check("mark_err", mark_err, exp_mark_err);
                check("free_count", free_count, model_free_pages());
                check("free_count_bound", free_count <= NP, 1);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        mark_valid = 0; free_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_free_count", free_count, NP);
        check("rst_busy", busy, 0);
        check("rst_free_ready", free_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mark_err", mark_err, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic do_mark(input int idx, input bit exp_err);
        @(negedge clk);
        mark_valid = 1; mark_idx = IW'(idx);
        @(negedge clk);
        mark_valid = 0;
        check("mark_err_pulse", mark_err, exp_err);
    endtask

    // Presents a request to an idle engine; returns the acceptance cycle.
    task automatic start_free(input longint a, input longint s, output int t0);
        @(negedge clk);
        free_valid = 1; free_addr = 32'(a); free_size = 33'(s);
        @(negedge clk);
        free_valid = 0;
        t0 = cyc;
    endtask

    task automatic do_free(input longint a, input longint s, input int est, input int epg, input int elat);
        int  t0;
        bit  seen;
        seen = 0;
        start_free(a, s, t0);
        for (int i = 0; i < 300 && !seen; i++) begin
            if (rsp_valid) begin
                seen = 1;
                check("rsp_latency", cyc + 1 - t0, elat);
                check("rsp_status_lit", rsp_status, est);
                check("rsp_pages_lit", rsp_pages, epg);
            end else begin
                check("ready_low_in_flight", free_ready, 0);
                @(negedge clk);
            end
        end
        if (!seen) check("rsp_timeout", 0, 1);
        @(negedge clk);
        check("ready_after_rsp", free_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  prev_ready;
        int  r;
        longint a, s;

        do_reset();

        // Release of three marked pages.
        do_mark(3, 0); do_mark(4, 0); do_mark(5, 0);
        check("count_after_marks", free_count, 61);
        do_free(64'h1000_3000, 64'h3000, 0, 3, 8);
        check("count_after_free", free_count, 64);

        // Alignment errors leave the pool alone.
        do_reset();
        do_free(64'h1000_3800, 64'h1000, 1, 0, 2);
        do_free(64'h1000_0000, 64'h0, 1, 0, 2);
        check("count_align", free_count, 64);

        // Range errors: past the end, below the base.
        do_free(64'h1003_F000, 64'h2000, 2, 0, 2);
        do_free(64'h0FFF_F000, 64'h1000, 2, 0, 2);

        // Double free on the second page; nothing is released.
        do_reset();
        do_mark(10, 0);
        do_free(64'h1000_A000, 64'h2000, 3, 0, 4);
        check("count_double", free_count, 63);

        // Re-marking an allocated page is an error (idx 64 is not encodable at 64 pages).
        do_reset();
        do_mark(7, 0);
        do_mark(7, 1);
        @(negedge clk);
        check("mark_err_one_cycle", mark_err, 0);
        check("count_remark", free_count, 63);

        // Asynchronous reset in the middle of a release.
        do_reset();
        for (int i = 0; i < 8; i++) do_mark(i, 0);
        check("count_8_marked", free_count, 56);
        start_free(64'h1000_0000, 64'h8000, t0);
        repeat (11) @(negedge clk);
        check("release_underway", free_count, 58);
        #2 rst_n = 1'b0;
        #1;
        check("midrel_free_count", free_count, NP);
        check("midrel_rsp_valid", rsp_valid, 0);
        check("midrel_busy", busy, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", free_ready, 1);
        do_mark(0, 0);

        // Randomized traffic against the model.
        do_reset();
        prev_ready = 1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (free_valid && prev_ready) free_valid = 0;
            mark_valid = ($urandom_range(0, 2) == 0);
            mark_idx   = IW'($urandom_range(0, NP - 1));
            if (!free_valid && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                a = BASE + longint'($urandom_range(0, NP - 1)) * PAGE;
                s = longint'($urandom_range(1, 4)) * PAGE;
                if (r == 7) a = a + 64'h800;
                else if (r == 8) s = 0;
                else if (r == 9) a = BASE - longint'($urandom_range(1, 8)) * PAGE;
                free_valid = 1; free_addr = 32'(a); free_size = 33'(s);
            end
            prev_ready = free_ready;
        end
        @(negedge clk);
        mark_valid = 0; free_valid = 0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
